dmem_mmio: RTL and testbench

- Data-memory stage directly downstream of the single-cycle ARM core.
- Consumes the core's data-side outputs: MemWrite, ALUResult (byte address) and WriteData. Returns ReadData combinationally, within the same cycle, as the single-cycle core requires.
- Holds a word-addressed data RAM and a memory-mapped I/O page.
- The I/O page contains a FIFO output port with a valid/ready handshake to an external consumer (display/serial), plus a free-running 32-bit timer.

---
 rtl/dmem_mmio.sv | 173 +++++++++++++++++
 tb/tb_dmem_mmio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory stage behind the single-cycle ARM core.
//
// Decodes the core's byte address into a word-addressed RAM (ALUResult[31]=0)
// or a small MMIO page (ALUResult[31]=1, decoded on ALUResult[3:2] only):
//   0x0 FIFO_DATA  write pushes into the output FIFO, reads 0
//   0x4 STATUS     {16'h0, count[7:0], 5'b0, overflow, empty, full}; any write clears overflow
//   0x8 TIMER      free-running 32-bit counter, write loads
//   0xC TCTRL      bit0 = timer enable
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   MemWrite   store strobe from the core
//   ALUResult  byte address from the core
//   WriteData  store data from the core
//   ReadData   combinational load data to the core
//   out_data   FIFO head word (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head word
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    REG_FIFO   = 2'd0,
    REG_STATUS = 2'd1,
    REG_TIMER  = 2'd2,
    REG_TCTRL  = 2'd3
  } mmio_reg_e;

  // Storage
  logic [31:0]   r_mem  [RAM_WORDS];
  logic [31:0]   r_fifo [FIFO_DEPTH];

  // MMIO state
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [31:0]   r_timer;
  logic          r_en;

  // Decode
  logic          w_is_mmio;
  logic [AW-1:0] w_ram_idx;
  mmio_reg_e     w_reg;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic [31:0]   w_status;
  logic [31:0]   w_mmio_rd;
  logic          w_unused;

  assign w_is_mmio = ALUResult[31];
  assign w_ram_idx = ALUResult[AW+1:2];
  assign w_reg     = mmio_reg_e'(ALUResult[3:2]);

  // Upper RAM address bits alias and the byte offset is ignored.
  assign w_unused  = ^{ALUResult[30:AW+2], ALUResult[1:0]};

  assign w_ram_we   = MemWrite & ~w_is_mmio;
  assign w_mmio_we  = MemWrite & w_is_mmio;
  assign w_push_req = w_mmio_we && (w_reg == REG_FIFO);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~w_empty & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_fifo[r_rptr];

  // RAM: write-at-edge, read returns the pre-edge word; contents not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

  // FIFO storage. When full with a simultaneous pop, wptr == rptr and the
  // slot being popped this cycle is overwritten at the same edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: setting takes priority over a STATUS-write clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_mmio_we && (w_reg == REG_STATUS)) begin
      r_ovf <= 1'b0;
    end
  end

  // Timer: a load beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_en    <= 1'b0;
    end else begin
      if (w_mmio_we && (w_reg == REG_TIMER)) begin
        r_timer <= WriteData;
      end else if (r_en) begin
        r_timer <= r_timer + 32'd1;
      end
      if (w_mmio_we && (w_reg == REG_TCTRL)) begin
        r_en <= WriteData[0];
      end
    end
  end

  assign w_status = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_empty, w_full};

  always_comb begin
    w_mmio_rd = '0;
    unique case (w_reg)
      REG_FIFO:   w_mmio_rd = '0;
      REG_STATUS: w_mmio_rd = w_status;
      REG_TIMER:  w_mmio_rd = r_timer;
      REG_TCTRL:  w_mmio_rd = {31'b0, r_en};
      default:    w_mmio_rd = '0;
    endcase
  end

  assign ReadData = w_is_mmio ? w_mmio_rd : r_mem[w_ram_idx];

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam logic [31:0] A_FIFO   = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_TIMER  = 32'h8000_0008;
  localparam logic [31:0] A_TCTRL  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [17];
  logic [31:0] sb [$];   // words expected to leave the FIFO, in order
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] rd_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample at the falling edge (pre-edge view), update
  // the FIFO model, then step past the rising edge.
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic pop;
    logic req;
    logic acc;
    MemWrite  = mw;
    ALUResult = a;
    WriteData = wd;
    out_ready = rdy;
    @(negedge clk);
    rd_s = ReadData;
    check("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() != 0)});
    if (sb.size() != 0) check("out_data", out_data, sb[0]);
    else                check("out_data_empty", out_data, 32'h0);
    pop = (sb.size() != 0) && rdy;
    req = mw && a[31] && (a[3:2] == 2'b00);
    acc = req && ((sb.size() < 4) || pop);
    if (pop) void'(sb.pop_front());
    if (acc) sb.push_back(wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[3]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0010, 32'hAAAA_5555, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hAAAA_5555};
    vt[6]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[7]  = '{1'b0, 32'h7FFF_FF14, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[8]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b0, 1'b1, 32'hAAAA_5555};
    vt[9]  = '{1'b0, A_FIFO,        32'h0,         1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b0, A_STATUS,      32'h0,         1'b0, 1'b1, 32'h2};
    vt[11] = '{1'b0, A_TIMER,       32'h0,         1'b0, 1'b1, 32'h0};
    vt[12] = '{1'b0, A_TCTRL,       32'h0,         1'b0, 1'b1, 32'h0};
    vt[13] = '{1'b0, 32'h8000_0017, 32'h0,         1'b0, 1'b1, 32'h2};
    vt[14] = '{1'b1, 32'h8000_001C, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0};
    vt[15] = '{1'b0, A_TCTRL,       32'h0,         1'b0, 1'b1, 32'h0};
    vt[16] = '{1'b0, A_TIMER,       32'h0,         1'b0, 1'b1, 32'h0};

    // Reset state
    ALUResult = A_STATUS;
    #1 reset = 1'b0;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_status", ReadData, 32'h2);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // RAM and MMIO decode vectors
    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].mw, vt[i].addr, vt[i].wd, vt[i].rdy);
      if (vt[i].chk) check($sformatf("vec%0d", i), rd_s, vt[i].exp);
    end

    // Overflow into a full FIFO, then drain in order
    for (int v = 1; v <= 4; v++) cyc(1'b1, A_FIFO, 32'(v), 1'b0);
    cyc(1'b1, A_FIFO, 32'd5, 1'b0);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    check("status_full_ovf", rd_s, 32'h0000_0405);
    cyc(1'b0, A_FIFO, 32'h0, 1'b1);
    check("fifo_data_read", rd_s, 32'h0);
    for (int k = 0; k < 3; k++) cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    check("status_empty_ovf", rd_s, 32'h0000_0006);
    cyc(1'b1, A_STATUS, 32'h0, 1'b0);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    check("status_cleared", rd_s, 32'h0000_0002);

    // Push into a full FIFO while its head is popped
    for (int v = 10; v <= 13; v++) cyc(1'b1, A_FIFO, 32'(v), 1'b0);
    cyc(1'b1, A_FIFO, 32'd9, 1'b1);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    check("status_push_pop", rd_s, 32'h0000_0401);
    for (int k = 0; k < 4; k++) cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    check("status_drained", rd_s, 32'h0000_0002);

    // Overflow cleared by a STATUS write on the following cycle
    for (int v = 20; v <= 23; v++) cyc(1'b1, A_FIFO, 32'(v), 1'b0);
    cyc(1'b1, A_FIFO, 32'd24, 1'b0);
    cyc(1'b1, A_STATUS, 32'h0, 1'b0);
    check("status_pre_clear", rd_s, 32'h0000_0405);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    check("status_post_clear", rd_s, 32'h0000_0401);
    for (int k = 0; k < 4; k++) cyc(1'b0, A_STATUS, 32'h0, 1'b1);

    // Timer
    cyc(1'b1, A_TCTRL, 32'h1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_10", rd_s, 32'd10);
    cyc(1'b1, A_TIMER, 32'hFFFF_FFFE, 1'b0);
    check("timer_pre_load", rd_s, 32'd11);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_load", rd_s, 32'hFFFF_FFFE);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_max", rd_s, 32'hFFFF_FFFF);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_wrap", rd_s, 32'h0);
    cyc(1'b1, A_TCTRL, 32'h0, 1'b0);
    check("tctrl_on", rd_s, 32'h1);
    cyc(1'b0, A_TCTRL, 32'h0, 1'b0);
    check("tctrl_off", rd_s, 32'h0);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_hold_a", rd_s, 32'd2);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("timer_hold_b", rd_s, 32'd2);

    // Mid-cycle reset with queued words and a running timer
    cyc(1'b1, A_TCTRL, 32'h1, 1'b0);
    for (int v = 31; v <= 33; v++) cyc(1'b1, A_FIFO, 32'(v), 1'b0);
    MemWrite  = 1'b0;
    ALUResult = A_STATUS;
    out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_status", ReadData, 32'h2);
    ALUResult = A_TIMER;
    #1;
    check("midrst_timer", ReadData, 32'h0);
    sb.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    check("postrst_status", rd_s, 32'h0000_0002);
    cyc(1'b0, A_TIMER, 32'h0, 1'b0);
    check("postrst_timer", rd_s, 32'h0);
    cyc(1'b0, A_TCTRL, 32'h0, 1'b0);
    check("postrst_tctrl", rd_s, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
